mem_access_stage: RTL and testbench

Memory-stage data access unit of the five-stage RISC-V core. It sits between the EX/MEM latch and the MEM/WB latch. It turns load/store control plus the ALU-computed address into a word-aligned request/ready transaction on the data-memory port, and stalls the pipeline until that transaction completes. Load data is sign- or zero-extended and presented on MemReadData for the MEM/WB latch to capture.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_access_stage_if.sv | 25 ++
 rtl/mem_align.sv | 69 ++++++
 rtl/mem_access_stage.sv | 131 +++++++++++++
 tb/tb_mem_access_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants and types for the memory access stage
// Contents: Funct3 access-size codes, byte-enable patterns, FSM state enum.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/ready port
// Signals: Dm_Req/Dm_We/Dm_Addr/Dm_WData/Dm_BE toward memory,
//          Dm_Ready/Dm_RData back from memory.
// Modports: master = access stage, slave = data memory.
interface mem_access_stage_if;

    logic        Dm_Req;
    logic        Dm_We;
    logic [31:0] Dm_Addr;
    logic [31:0] Dm_WData;
    logic [3:0]  Dm_BE;
    logic        Dm_Ready;
    logic [31:0] Dm_RData;

    modport master (
        output Dm_Req, Dm_We, Dm_Addr, Dm_WData, Dm_BE,
        input  Dm_Ready, Dm_RData
    );

    modport slave (
        input  Dm_Req, Dm_We, Dm_Addr, Dm_WData, Dm_BE,
        output Dm_Ready, Dm_RData
    );

endinterface

// File: rtl/mem_align.sv
// rtl/mem_align.sv - combinational store formatting, alignment check, load extension
// Ports: is_store_i/funct3_i/addr_lo_i/rs2_i  current instruction
//        wdata_o/be_o/legal_o/aligned_o       formatted store and access checks
//        ld_funct3_i/ld_off_i/rdata_i         latched load size/offset and bus word
//        ld_data_o                            extended load result
module mem_align
    import mem_stage_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        legal_o,
    output logic        aligned_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] lane_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wdata_o   = rs2_i;
        be_o      = BE_NONE;
        legal_o   = 1'b0;
        aligned_o = 1'b1;
        case (funct3_i)
            F3_B, F3_BU: begin
                wdata_o = {4{rs2_i[7:0]}};
                be_o    = BE_BYTE << addr_lo_i;
                // Unsigned variants exist only for loads.
                legal_o = !is_store_i || (funct3_i == F3_B);
            end
            F3_H, F3_HU: begin
                wdata_o   = {2{rs2_i[15:0]}};
                be_o      = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                legal_o   = !is_store_i || (funct3_i == F3_H);
                aligned_o = !addr_lo_i[0];
            end
            F3_W: begin
                be_o      = BE_WORD;
                legal_o   = 1'b1;
                aligned_o = (addr_lo_i == 2'b00);
            end
            default: ;
        endcase
    end

    assign lane_shift = rdata_i >> {ld_off_i, 3'b000};
    assign ld_byte    = lane_shift[7:0];
    assign ld_half    = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        ld_data_o = rdata_i;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'h0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'h0, ld_half};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store unit with request/ready bus and stall
// Ports: clk, reset (sync, active-high)
//        MemRead/MemWrite/Funct3/Alu_Result/Rs2_Data  from EX/MEM latch
//        dm (master)                                  data-memory port
//        MemReadData                                  extended load data to MEM/WB
//        Stall/Misaligned                             combinational pipeline controls
//        Timeout                                      one-cycle pulse in DONE after abort
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [2:0]          Funct3,
    input  logic [31:0]         Alu_Result,
    input  logic [31:0]         Rs2_Data,
    mem_access_stage_if.master  dm,
    output logic [31:0]         MemReadData,
    output logic                Stall,
    output logic                Misaligned,
    output logic                Timeout
);

    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    state_e      state_q;
    logic [WW-1:0] wait_q, wait_d;
    logic        req_q, we_q, timeout_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic [31:0] al_wdata, al_ld_data;
    logic [3:0]  al_be;
    logic        al_legal, al_aligned;
    logic        is_access, access_ok;

    mem_align u_align (
        .is_store_i  (MemWrite),
        .funct3_i    (Funct3),
        .addr_lo_i   (Alu_Result[1:0]),
        .rs2_i       (Rs2_Data),
        .wdata_o     (al_wdata),
        .be_o        (al_be),
        .legal_o     (al_legal),
        .aligned_o   (al_aligned),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .rdata_i     (dm.Dm_RData),
        .ld_data_o   (al_ld_data)
    );

    assign is_access = MemRead | MemWrite;
    assign access_ok = is_access && al_legal && al_aligned;
    assign wait_d    = wait_q + 1'b1;

    assign Stall      = !reset && (((state_q == IDLE) && access_ok) || (state_q == ACCESS));
    assign Misaligned = !reset && (state_q == IDLE) && is_access && al_legal && !al_aligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= BE_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            f3_q      <= F3_B;
            off_q     <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access_ok) begin
                        state_q <= ACCESS;
                        req_q   <= 1'b1;
                        we_q    <= MemWrite;
                        be_q    <= al_be;
                        addr_q  <= {Alu_Result[31:2], 2'b00};
                        wdata_q <= al_wdata;
                        f3_q    <= Funct3;
                        off_q   <= Alu_Result[1:0];
                        wait_q  <= '0;
                    end else if (Misaligned && !MemWrite) begin
                        rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    // Ready is checked first so it wins over a same-cycle timeout.
                    if (dm.Dm_Ready) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= BE_NONE;
                        if (!we_q) rdata_q <= al_ld_data;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q   <= DONE;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        be_q      <= BE_NONE;
                        timeout_q <= 1'b1;
                        wait_q    <= wait_d;
                        if (!we_q) rdata_q <= '0;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dm.Dm_Req   = req_q;
    assign dm.Dm_We    = we_q;
    assign dm.Dm_BE    = be_q;
    assign dm.Dm_Addr  = addr_q;
    assign dm.Dm_WData = wdata_q;
    assign MemReadData = rdata_q;
    assign Timeout     = timeout_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Alu_Result, Rs2_Data;
    logic [31:0] MemReadData;
    logic        Stall, Misaligned, Timeout;

    mem_access_stage_if dm ();

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Funct3      (Funct3),
        .Alu_Result  (Alu_Result),
        .Rs2_Data    (Rs2_Data),
        .dm          (dm.master),
        .MemReadData (MemReadData),
        .Stall       (Stall),
        .Misaligned  (Misaligned),
        .Timeout     (Timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int          stall_cnt, req_cnt;
    logic        done_ok, done_to, done_req, cap_we;
    logic [3:0]  cap_be, done_be;
    logic [31:0] cap_addr, cap_wdata, done_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one access and follows it cycle by cycle until the first
    // non-stalled cycle after the stall (DONE). Returns in the DONE cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int wait_n,
                              input logic rdy_idle);
        int  n_acc;
        bit  seen;
        MemRead     = rd;
        MemWrite    = wr;
        Funct3      = f3;
        Alu_Result  = addr;
        Rs2_Data    = rs2;
        dm.Dm_RData = rdata;
        dm.Dm_Ready = rdy_idle;
        stall_cnt = 0;
        req_cnt   = 0;
        n_acc     = 0;
        seen      = 0;
        done_ok   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (Stall) begin
                stall_cnt++;
                seen = 1;
            end
            if (dm.Dm_Req) begin
                req_cnt++;
                n_acc++;
                cap_addr  = dm.Dm_Addr;
                cap_we    = dm.Dm_We;
                cap_be    = dm.Dm_BE;
                cap_wdata = dm.Dm_WData;
                dm.Dm_Ready = (n_acc > wait_n);
            end else begin
                dm.Dm_Ready = rdy_idle;
            end
            if (seen && !Stall) begin
                done_ok    = 1'b1;
                done_rdata = MemReadData;
                done_to    = Timeout;
                done_req   = dm.Dm_Req;
                done_be    = dm.Dm_BE;
                MemRead    = 1'b0;
                MemWrite   = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("done_reached", {31'h0, done_ok}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        MemRead     = 1'b1;
        MemWrite    = 1'b0;
        Funct3      = F3_W;
        Alu_Result  = 32'h100;
        Rs2_Data    = 32'h0;
        dm.Dm_Ready = 1'b0;
        dm.Dm_RData = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",     {31'h0, dm.Dm_Req}, 32'h0);
        check("rst_be",      {28'h0, dm.Dm_BE}, 32'h0);
        check("rst_addr",    dm.Dm_Addr, 32'h0);
        check("rst_wdata",   dm.Dm_WData, 32'h0);
        check("rst_rdata",   MemReadData, 32'h0);
        check("rst_timeout", {31'h0, Timeout}, 32'h0);
        check("rst_stall",   {31'h0, Stall}, 32'h0);
        MemRead = 1'b0;
        reset   = 1'b0;
        @(negedge clk);

        // sw 0x104
        run_access(1'b0, 1'b1, F3_W, 32'h104, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        check("sw_addr",   cap_addr, 32'h104);
        check("sw_be",     {28'h0, cap_be}, 32'hF);
        check("sw_wdata",  cap_wdata, 32'hDEADBEEF);
        check("sw_we",     {31'h0, cap_we}, 32'h1);
        check("sw_stalls", stall_cnt, 2);
        check("sw_req_done", {31'h0, done_req}, 32'h0);
        check("sw_be_done",  {28'h0, done_be}, 32'h0);

        // lb 0x203, ready on the cycle the wait limit is also reached
        run_access(1'b1, 1'b0, F3_B, 32'h203, 32'h0, 32'h80FF1234, 3, 1'b0);
        check("lb_data",   done_rdata, 32'hFFFFFF80);
        check("lb_stalls", stall_cnt, 5);
        check("lb_addr",   cap_addr, 32'h200);
        check("lb_we",     {31'h0, cap_we}, 32'h0);
        check("lb_timeout", {31'h0, done_to}, 32'h0);

        run_access(1'b1, 1'b0, F3_BU, 32'h203, 32'h0, 32'h80FF1234, 3, 1'b0);
        check("lbu_data",   done_rdata, 32'h00000080);
        check("lbu_stalls", stall_cnt, 5);

        // sh 0x12
        run_access(1'b0, 1'b1, F3_H, 32'h12, 32'h0000ABCD, 32'h0, 0, 1'b0);
        check("sh_be",    {28'h0, cap_be}, 32'hC);
        check("sh_wdata", cap_wdata, 32'hABCDABCD);
        check("sh_addr",  cap_addr, 32'h10);

        // lh 0x101 misaligned
        MemRead    = 1'b1;
        MemWrite   = 1'b0;
        Funct3     = F3_H;
        Alu_Result = 32'h101;
        @(negedge clk);
        #1;
        check("mis_flag",  {31'h0, Misaligned}, 32'h1);
        check("mis_stall", {31'h0, Stall}, 32'h0);
        check("mis_req",   {31'h0, dm.Dm_Req}, 32'h0);
        @(negedge clk);
        #1;
        check("mis_rdata", MemReadData, 32'h0);
        check("mis_req2",  {31'h0, dm.Dm_Req}, 32'h0);
        Funct3     = 3'b011;
        Alu_Result = 32'h100;
        #1;
        check("ill_mis",   {31'h0, Misaligned}, 32'h0);
        check("ill_stall", {31'h0, Stall}, 32'h0);
        MemRead = 1'b0;
        @(negedge clk);

        run_access(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h80012345, 0, 1'b0);
        check("lhu_data", done_rdata, 32'h00008001);

        // lw timeout with Dm_Ready never asserted
        run_access(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'h55555555, 1000, 1'b0);
        check("to_flag",   {31'h0, done_to}, 32'h1);
        check("to_rdata",  done_rdata, 32'h0);
        check("to_stalls", stall_cnt, 5);
        check("to_reqs",   req_cnt, 4);
        @(negedge clk);
        #1;
        check("to_pulse",  {31'h0, Timeout}, 32'h0);
        check("to_idle",   {31'h0, Stall}, 32'h0);

        run_access(1'b1, 1'b0, F3_H, 32'h002, 32'h0, 32'h80012345, 0, 1'b0);
        check("lh_data", done_rdata, 32'hFFFF8001);

        // reset in the 2nd ACCESS cycle of a load
        MemRead    = 1'b1;
        MemWrite   = 1'b0;
        Funct3     = F3_W;
        Alu_Result = 32'h500;
        dm.Dm_Ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst2_req_before", {31'h0, dm.Dm_Req}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst2_stall_held", {31'h0, Stall}, 32'h0);
        @(negedge clk);
        #1;
        check("rst2_req",   {31'h0, dm.Dm_Req}, 32'h0);
        check("rst2_be",    {28'h0, dm.Dm_BE}, 32'h0);
        check("rst2_addr",  dm.Dm_Addr, 32'h0);
        check("rst2_wdata", dm.Dm_WData, 32'h0);
        check("rst2_rdata", MemReadData, 32'h0);
        reset   = 1'b0;
        MemRead = 1'b0;
        @(negedge clk);
        run_access(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h12345678, 1, 1'b0);
        check("post_rst_data",   done_rdata, 32'h12345678);
        check("post_rst_stalls", stall_cnt, 3);

        // back-to-back lw then sw with Dm_Ready always high
        run_access(1'b1, 1'b0, F3_W, 32'h0, 32'h0, 32'hCAFEF00D, 0, 1'b1);
        check("b2b_lw_data",   done_rdata, 32'hCAFEF00D);
        check("b2b_lw_reqs",   req_cnt, 1);
        check("b2b_lw_stalls", stall_cnt, 2);
        check("b2b_done_req",  {31'h0, done_req}, 32'h0);
        run_access(1'b0, 1'b1, F3_W, 32'h4, 32'h11223344, 32'hCAFEF00D, 0, 1'b1);
        check("b2b_sw_reqs",   req_cnt, 1);
        check("b2b_sw_addr",   cap_addr, 32'h4);
        check("b2b_sw_we",     {31'h0, cap_we}, 32'h1);
        check("b2b_sw_wdata",  cap_wdata, 32'h11223344);
        check("b2b_sw_stalls", stall_cnt, 2);
        check("b2b_sw_keep_rdata", done_rdata, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
